glitch_sweep_ctrl: RTL and testbench

//   Sequencer that drives the glitch generator through a 2-D parameter sweep
//   (trigger-to-glitch delay x glitch width). Each attempt: program delay/width,

---
 rtl/glitch_sweep_ctrl.sv | 116 +++++++++++
 tb/tb_glitch_sweep_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/glitch_sweep_ctrl.sv
// glitch_sweep_ctrl: walks a delay x width grid, arming the glitch generator once per point
// and stopping on target success, grid exhaustion or abort.
module glitch_sweep_ctrl #(
    parameter int DW          = 32,
    parameter int WW          = 16,
    parameter int DELAY_START = 100,
    parameter int DELAY_STEP  = 10,
    parameter int DELAY_END   = 1000,
    parameter int WIDTH_START = 1,
    parameter int WIDTH_STEP  = 1,
    parameter int WIDTH_END   = 12,
    parameter int SETTLE      = 1200,
    parameter int TIMEOUT     = 24000000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          gen_done,
    input  logic          target_ok,
    output logic          arm,
    output logic [DW-1:0] delay_cfg,
    output logic [WW-1:0] width_cfg,
    output logic          busy,
    output logic          sweep_done,
    output logic          found,
    output logic          timeout_err,
    output logic [31:0]   attempts
);
    typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_SETTLE, S_STEP, S_FINISH} state_t;

    localparam logic [DW-1:0] D_START = DW'(DELAY_START);
    localparam logic [DW:0]   D_STEP  = (DW+1)'(DELAY_STEP);
    localparam logic [DW:0]   D_END   = (DW+1)'(DELAY_END);
    localparam logic [WW-1:0] W_START = WW'(WIDTH_START);
    localparam logic [WW:0]   W_STEP  = (WW+1)'(WIDTH_STEP);
    localparam logic [WW:0]   W_END   = (WW+1)'(WIDTH_END);
    localparam logic [31:0]   TO_LAST = 32'(TIMEOUT - 1);
    localparam logic [31:0]   ST_LAST = 32'(SETTLE - 1);

    state_t      state, state_n;
    logic [31:0] cnt;
    logic [WW:0] w_sum;
    logic [DW:0] d_sum;
    logic        w_ok, d_ok, timed_out;

    // One extra bit keeps the carry, so an overflowing step reads as "past the end".
    assign w_sum     = {1'b0, width_cfg} + W_STEP;
    assign d_sum     = {1'b0, delay_cfg} + D_STEP;
    assign w_ok      = w_sum <= W_END;
    assign d_ok      = d_sum <= D_END;
    assign timed_out = !gen_done && cnt == TO_LAST;

    assign arm        = state == S_ARM && !abort;
    assign sweep_done = state == S_FINISH && !abort;
    assign busy       = state != S_IDLE;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   state_n = start ? S_ARM : S_IDLE;
            S_ARM:    state_n = S_WAIT;
            S_WAIT:   state_n = gen_done ? S_SETTLE : (timed_out ? S_STEP : S_WAIT);
            S_SETTLE: state_n = target_ok ? S_FINISH : (cnt == ST_LAST ? S_STEP : S_SETTLE);
            S_STEP:   state_n = (w_ok || d_ok) ? S_ARM : S_FINISH;
            S_FINISH: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
        if (abort)
            state_n = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // The cycle counter restarts on every state change, so it measures time spent in the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            delay_cfg   <= D_START;
            width_cfg   <= W_START;
            found       <= 1'b0;
            timeout_err <= 1'b0;
            attempts    <= '0;
        end else begin
            cnt <= (state_n == state) ? cnt + 32'd1 : '0;
            if (!abort) begin
                case (state)
                    S_IDLE: if (start) begin
                        delay_cfg   <= D_START;
                        width_cfg   <= W_START;
                        found       <= 1'b0;
                        timeout_err <= 1'b0;
                        attempts    <= '0;
                    end
                    S_ARM:    if (attempts != '1) attempts <= attempts + 32'd1;
                    S_WAIT:   if (timed_out) timeout_err <= 1'b1;
                    S_SETTLE: if (target_ok) found <= 1'b1;
                    S_STEP: begin
                        if (w_ok)
                            width_cfg <= w_sum[WW-1:0];
                        else if (d_ok) begin
                            width_cfg <= W_START;
                            delay_cfg <= d_sum[DW-1:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
// tb_glitch_sweep_ctrl: directed checks of the sweep order, success stop, timeout, abort, reset
// and end-of-range width handling.
module tb_glitch_sweep_ctrl;
    logic        clk = 0, rst_n = 0, start = 0, abort = 0, gen_done = 0, target_ok = 0;
    logic        arm, busy, sweep_done, found, timeout_err;
    logic [31:0] delay_cfg, attempts;
    logic [15:0] width_cfg;
    logic        start2 = 0;
    logic        arm2, busy2, sweep_done2, found2, timeout_err2;
    logic [31:0] delay2, attempts2;
    logic [3:0]  width2;

    int n_chk = 0, n_err = 0;
    int sd_cnt = 0, sd2_cnt = 0, gd_cnt = 0, cyc = 0;
    bit resp_en = 1, tgt_mode = 0;
    logic [47:0] q[$];
    int          qc[$];
    logic [35:0] q2[$];

    glitch_sweep_ctrl #(.DW(32), .WW(16), .DELAY_START(10), .DELAY_STEP(10), .DELAY_END(30),
        .WIDTH_START(1), .WIDTH_STEP(1), .WIDTH_END(3), .SETTLE(4), .TIMEOUT(50)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gen_done(gen_done),
        .target_ok(target_ok), .arm(arm), .delay_cfg(delay_cfg), .width_cfg(width_cfg),
        .busy(busy), .sweep_done(sweep_done), .found(found), .timeout_err(timeout_err),
        .attempts(attempts));

    glitch_sweep_ctrl #(.DW(32), .WW(4), .DELAY_START(10), .DELAY_STEP(10), .DELAY_END(20),
        .WIDTH_START(1), .WIDTH_STEP(2), .WIDTH_END(15), .SETTLE(2), .TIMEOUT(50)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0), .gen_done(1'b1),
        .target_ok(1'b0), .arm(arm2), .delay_cfg(delay2), .width_cfg(width2),
        .busy(busy2), .sweep_done(sweep_done2), .found(found2), .timeout_err(timeout_err2),
        .attempts(attempts2));

    always #5 clk = ~clk;

    // Generator/target model and event recorder, all on the falling edge.
    initial forever begin
        @(negedge clk);
        cyc++;
        gen_done = (gd_cnt == 1);
        if (gd_cnt > 0) gd_cnt--;
        if (arm) begin
            q.push_back({delay_cfg, width_cfg});
            qc.push_back(cyc);
            if (resp_en) gd_cnt = 5;
        end
        if (sweep_done) sd_cnt++;
        if (arm2) q2.push_back({delay2, width2});
        if (sweep_done2) sd2_cnt++;
        target_ok = tgt_mode && delay_cfg == 32'd20 && width_cfg == 16'd2;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1;
        tick(1);
        start = 0;
    endtask

    task automatic wait_sd(input int base, input int lim);
        int k = 0;
        while (sd_cnt == base && k < lim) begin
            tick(1);
            k++;
        end
        check("sweep_done_seen", 64'(k < lim), 64'd1);
    endtask

    task automatic wait_arm(input int lim);
        int k = 0;
        while (q.size() == 0 && k < lim) begin
            tick(1);
            k++;
        end
        check("arm_seen", 64'(k < lim), 64'd1);
    endtask

    initial begin
        int base;
        tick(2);
        check("rst_busy", busy, 0);
        check("rst_arm", arm, 0);
        check("rst_sweep_done", sweep_done, 0);
        check("rst_found", found, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_attempts", attempts, 0);
        check("rst_delay", delay_cfg, 10);
        check("rst_width", width_cfg, 1);
        rst_n = 1;
        tick(2);

        // Full sweep, no success; a second start mid-sweep must be ignored.
        q.delete(); qc.delete(); base = sd_cnt;
        pulse_start();
        tick(20);
        pulse_start();
        wait_sd(base, 500);
        tick(3);
        check("full_n_arms", q.size(), 9);
        for (int i = 0; i < 9 && i < q.size(); i++)
            check($sformatf("full_cfg%0d", i), q[i], {32'(10 + 10 * (i / 3)), 16'(1 + i % 3)});
        if (qc.size() > 1) check("full_arm_spacing", qc[1] - qc[0], 11);
        check("full_sd_count", sd_cnt - base, 1);
        check("full_found", found, 0);
        check("full_attempts", attempts, 9);
        check("full_timeout_err", timeout_err, 0);
        check("full_busy", busy, 0);

        // Asynchronous reset while waiting for gen_done.
        q.delete();
        pulse_start();
        wait_arm(10);
        tick(2);
        check("pre_rst_busy", busy, 1);
        rst_n = 0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_attempts", attempts, 0);
        check("mid_rst_delay", delay_cfg, 10);
        check("mid_rst_width", width_cfg, 1);
        tick(1);
        rst_n = 1;
        tick(1);
        check("post_rst_busy", busy, 0);
        tick(20);

        // Success on (20,2); target_ok is also high outside SETTLE there and must be ignored.
        tgt_mode = 1;
        q.delete(); base = sd_cnt;
        pulse_start();
        wait_sd(base, 500);
        tick(1);
        tgt_mode = 0;
        tick(2);
        check("found_n_arms", q.size(), 5);
        check("found_flag", found, 1);
        check("found_delay", delay_cfg, 20);
        check("found_width", width_cfg, 2);
        check("found_attempts", attempts, 5);
        check("found_sd_count", sd_cnt - base, 1);

        // start and abort together in IDLE: nothing happens.
        start = 1; abort = 1;
        tick(1);
        start = 0; abort = 0;
        check("start_abort_busy", busy, 0);
        check("start_abort_found", found, 1);
        check("start_abort_attempts", attempts, 5);
        tick(5);

        // Abort in the third SETTLE cycle.
        q.delete(); base = sd_cnt;
        pulse_start();
        wait_arm(10);
        tick(8);
        check("abort_pre_busy", busy, 1);
        abort = 1;
        tick(1);
        abort = 0;
        check("abort_busy", busy, 0);
        tick(30);
        check("abort_n_arms", q.size(), 1);
        check("abort_no_sd", sd_cnt - base, 0);
        check("abort_attempts", attempts, 1);
        q.delete();
        pulse_start();
        wait_arm(10);
        if (q.size() > 0) check("restart_cfg", q[0], {32'd10, 16'd1});
        abort = 1;
        tick(1);
        abort = 0;
        tick(20);

        // Generator never finishes: every attempt times out after 50 cycles.
        resp_en = 0;
        q.delete(); qc.delete(); base = sd_cnt;
        pulse_start();
        wait_sd(base, 1000);
        tick(2);
        check("to_n_arms", q.size(), 9);
        if (qc.size() > 1) check("to_arm_spacing", qc[1] - qc[0], 52);
        if (q.size() > 8) check("to_last_cfg", q[8], {32'd30, 16'd3});
        check("to_flag", timeout_err, 1);
        check("to_found", found, 0);
        check("to_attempts", attempts, 9);

        // Width range ending at the top of its field, odd step.
        q2.delete(); base = sd2_cnt;
        start2 = 1;
        tick(1);
        start2 = 0;
        for (int k = 0; k < 500 && sd2_cnt == base; k++) tick(1);
        tick(2);
        check("wrap_sd_count", sd2_cnt - base, 1);
        check("wrap_n_arms", q2.size(), 16);
        for (int i = 0; i < 16 && i < q2.size(); i++)
            check($sformatf("wrap_cfg%0d", i), q2[i], {32'(10 + 10 * (i / 8)), 4'(1 + 2 * (i % 8))});
        check("wrap_attempts", attempts2, 16);
        check("wrap_busy", busy2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
